// File: rtl/bsram_port_arbiter_if.sv
// Requester-side bus of the BSRAM port arbiter: per-channel request fields,
// one-hot accept strobe and the shared read-response return path.
interface bsram_port_arbiter_if #(
   parameter int NCH = 3,
   parameter int AW  = 15,
   parameter int DW  = 8
);
   logic [NCH-1:0]    req_valid;
   logic [NCH-1:0]    req_we;
   logic [NCH-1:0]    req_lock;
   logic [NCH*AW-1:0] req_addr;
   logic [NCH*DW-1:0] req_wdata;
   logic [NCH-1:0]    req_ready;
   logic [NCH-1:0]    rsp_valid;
   logic [DW-1:0]     rsp_data;

   modport master (
      output req_valid, req_we, req_lock, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  req_valid, req_we, req_lock, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/bsram_port_arbiter.sv
// N-channel arbiter sharing one single-port BSRAM: fixed-priority or
// round-robin selection, bounded burst locking and latency-matched read
// response routing back to the requesting channel.
module bsram_port_arbiter #(
   parameter int NCH       = 3,
   parameter int AW        = 15,
   parameter int DW        = 8,
   parameter int RD_LAT    = 1,
   parameter int RR_MODE   = 1,
   parameter int MAX_BURST = 4
) (
   input  logic                MEMORY_CLK,
   input  logic                rst_n,
   bsram_port_arbiter_if.slave bus,
   output logic                mem_ce,
   output logic                mem_we,
   output logic [AW-1:0]       mem_ad,
   output logic [DW-1:0]       mem_din,
   input  logic [DW-1:0]       mem_dout,
   output logic [2:0]          grant_id,
   output logic                busy
);
   localparam int         PW   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   logic [PW-1:0]  ptr;
   logic [3:0]     burst_cnt;
   logic           prev_xfer;
   logic [AW-1:0]  ad_q;
   logic [DW-1:0]  din_q;
   logic [NCH-1:0] gmask, others, cand, win_oh;
   logic [2:0]     win_id;
   logic           hold, found, xfer, rd_xfer;
   int             idx;

   logic [RD_LAT:1] vld_pipe;
   logic [2:0]      id_pipe [1:RD_LAT];

   // one-hot mask of the most recent grant, used for lock and exclusion
   for (genvar i = 0; i < NCH; i++) begin : g_mask
      assign gmask[i] = (grant_id == 3'(i));
   end

   // winner select: lock hold first, then priority search over candidates
   always_comb begin
      hold   = prev_xfer && |(gmask & bus.req_valid & bus.req_lock) && (burst_cnt < MAXB);
      others = bus.req_valid & ~gmask;
      cand   = (prev_xfer && burst_cnt >= MAXB && |others) ? others : bus.req_valid;
      win_oh = '0;
      win_id = grant_id;
      found  = 1'b0;
      idx    = 0;
      if (hold) begin
         win_oh = gmask & bus.req_valid;
      end else begin
         for (int k = 0; k < NCH; k++) begin
            idx = (RR_MODE != 0) ? int'(ptr) + k : k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && cand[idx]) begin
               found       = 1'b1;
               win_oh[idx] = 1'b1;
               win_id      = 3'(idx);
            end
         end
      end
   end

   // memory-side mux; address and write data park on the last value when idle
   always_comb begin
      mem_ad  = ad_q;
      mem_din = din_q;
      mem_we  = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (win_oh[i]) begin
            mem_ad  = bus.req_addr[i*AW +: AW];
            mem_din = bus.req_wdata[i*DW +: DW];
            mem_we  = bus.req_we[i];
         end
      end
   end

   assign mem_ce        = |bus.req_valid;
   assign bus.req_ready = win_oh;
   assign xfer          = |win_oh;
   assign rd_xfer       = xfer & ~mem_we;

   // arbiter state: rotation pointer, burst counter, last grant
   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         burst_cnt <= '0;
         grant_id  <= '0;
         prev_xfer <= 1'b0;
         ad_q      <= '0;
         din_q     <= '0;
      end else begin
         prev_xfer <= xfer;
         ad_q      <= mem_ad;
         din_q     <= mem_din;
         if (xfer) begin
            grant_id  <= win_id;
            burst_cnt <= hold ? burst_cnt + 4'd1 : 4'd1;
            ptr       <= (win_id == 3'(NCH-1)) ? '0 : PW'(win_id + 3'd1);
         end
      end
   end

   // read-response pipeline carrying {valid, id} for RD_LAT cycles
   always_ff @(posedge MEMORY_CLK or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int s = 1; s <= RD_LAT; s++) id_pipe[s] <= '0;
      end else begin
         vld_pipe[1] <= rd_xfer;
         id_pipe[1]  <= win_id;
         for (int s = 2; s <= RD_LAT; s++) begin
            vld_pipe[s] <= vld_pipe[s-1];
            id_pipe[s]  <= id_pipe[s-1];
         end
      end
   end

   for (genvar i = 0; i < NCH; i++) begin : g_rsp
      assign bus.rsp_valid[i] = vld_pipe[RD_LAT] && (id_pipe[RD_LAT] == 3'(i));
   end

   assign bus.rsp_data = vld_pipe[RD_LAT] ? mem_dout : '0;
   assign busy         = |vld_pipe;
endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Bench: fixed-priority instance (RD_LAT=1) and round-robin instance
// (RD_LAT=2, MAX_BURST=4), each with a BSRAM model and a response scoreboard.
module tb_bsram_port_arbiter;
   localparam int NCH = 3, AW = 15, DW = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0, failures = 0;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // stimulus registers, index 0 = fixed DUT, 1 = round-robin DUT
   logic [2:0]  v [2], w [2], l [2];
   logic [44:0] a [2];
   logic [23:0] d [2];

   logic        ce_o [2], we_o [2], busy_o [2];
   logic [14:0] ad_o [2];
   logic [7:0]  din_o [2], dout_i [2], rspd [2];
   logic [2:0]  gid_o [2], rdy [2], rspv [2];

   bsram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) bf ();
   bsram_port_arbiter_if #(.NCH(NCH), .AW(AW), .DW(DW)) br ();

   assign bf.req_valid = v[0]; assign bf.req_we = w[0]; assign bf.req_lock = l[0];
   assign bf.req_addr  = a[0]; assign bf.req_wdata = d[0];
   assign br.req_valid = v[1]; assign br.req_we = w[1]; assign br.req_lock = l[1];
   assign br.req_addr  = a[1]; assign br.req_wdata = d[1];
   assign rdy[0] = bf.req_ready; assign rspv[0] = bf.rsp_valid; assign rspd[0] = bf.rsp_data;
   assign rdy[1] = br.req_ready; assign rspv[1] = br.rsp_valid; assign rspd[1] = br.rsp_data;

   bsram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(1), .RR_MODE(0), .MAX_BURST(4)) dut_f (
      .MEMORY_CLK(clk), .rst_n(rst_n), .bus(bf.slave),
      .mem_ce(ce_o[0]), .mem_we(we_o[0]), .mem_ad(ad_o[0]), .mem_din(din_o[0]),
      .mem_dout(dout_i[0]), .grant_id(gid_o[0]), .busy(busy_o[0]));

   bsram_port_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(2), .RR_MODE(1), .MAX_BURST(4)) dut_r (
      .MEMORY_CLK(clk), .rst_n(rst_n), .bus(br.slave),
      .mem_ce(ce_o[1]), .mem_we(we_o[1]), .mem_ad(ad_o[1]), .mem_din(din_o[1]),
      .mem_dout(dout_i[1]), .grant_id(gid_o[1]), .busy(busy_o[1]));

   // BSRAM models: synchronous read, latency 1 and 2
   logic [7:0] mem_f [0:32767], mem_r [0:32767], shadow [0:32767];
   logic [7:0] rf0, rr0, rr1;
   always @(posedge clk) begin
      if (ce_o[0]) begin
         if (we_o[0]) mem_f[ad_o[0]] <= din_o[0];
         else         rf0 <= mem_f[ad_o[0]];
      end
      if (ce_o[1]) begin
         if (we_o[1]) mem_r[ad_o[1]] <= din_o[1];
         else         rr0 <= mem_r[ad_o[1]];
      end
      rr1 <= rr0;
   end
   assign dout_i[0] = rf0;
   assign dout_i[1] = rr1;

   function automatic logic [7:0] pat(logic [14:0] ad);
      return ad[7:0] ^ ad[14:7] ^ 8'h3C;
   endfunction

   typedef struct { int ch; logic [7:0] dat; int t; } exp_t;
   exp_t q0 [$], q1 [$];

   // scoreboards: every response must match the oldest expected read
   always @(negedge clk) begin
      exp_t e;
      if (rspv[0] != 3'b000) begin
         if (q0.size() == 0) chk("f_rsp_unexpected", 32'(rspv[0]), 0);
         else begin
            e = q0.pop_front();
            chk("f_rsp_ch", 32'(rspv[0]), 32'(1 << e.ch));
            chk("f_rsp_data", 32'(rspd[0]), 32'(e.dat));
            chk("f_rsp_lat", cyc, e.t);
         end
      end
   end
   always @(negedge clk) begin
      exp_t e;
      if (rspv[1] != 3'b000) begin
         if (q1.size() == 0) chk("r_rsp_unexpected", 32'(rspv[1]), 0);
         else begin
            e = q1.pop_front();
            chk("r_rsp_ch", 32'(rspv[1]), 32'(1 << e.ch));
            chk("r_rsp_data", 32'(rspd[1]), 32'(e.dat));
            chk("r_rsp_lat", cyc, e.t);
         end
      end
   end

   task automatic drv(int s, logic [2:0] vv, ww, ll, logic [14:0] a0, a1, a2, logic [7:0] wd);
      v[s] = vv; w[s] = ww; l[s] = ll;
      a[s] = {a2, a1, a0};
      d[s] = {wd, wd, wd};
   endtask

   // check one arbitration cycle, record the expected response, advance
   task automatic cyc_chk(int s, string tag, logic [2:0] er);
      int          ch;
      logic [14:0] ad;
      exp_t        e;
      #2;
      chk({tag, "_rdy"}, 32'(rdy[s]), 32'(er));
      chk({tag, "_ce"}, 32'(ce_o[s]), 32'(v[s] != 3'b000));
      if (er != 3'b000) begin
         ch = 0;
         for (int i = 0; i < NCH; i++) if (er[i]) ch = i;
         ad = a[s][ch*AW +: AW];
         chk({tag, "_ad"}, 32'(ad_o[s]), 32'(ad));
         chk({tag, "_we"}, 32'(we_o[s]), 32'(w[s][ch]));
         if (w[s][ch]) begin
            if (s == 1) shadow[ad] = d[s][ch*DW +: DW];
         end else begin
            e.ch = ch; e.dat = shadow[ad]; e.t = cyc + ((s == 0) ? 1 : 2);
            if (s == 0) q0.push_back(e); else q1.push_back(e);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle(int s, int n);
      drv(s, 3'b000, 3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 8'h00);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   logic [2:0] burst_exp [0:8] = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b100,
                                   3'b100, 3'b100, 3'b100, 3'b001};

   initial begin
      for (int i = 0; i < 32768; i++) begin
         mem_f[i] = pat(15'(i)); mem_r[i] = pat(15'(i)); shadow[i] = pat(15'(i));
      end
      mem_f[15'h1234] = 8'hA5; mem_r[15'h1234] = 8'hA5; shadow[15'h1234] = 8'hA5;
      drv(0, 3'b000, 3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 8'h00);
      drv(1, 3'b000, 3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 8'h00);
      rst_n = 1'b0;
      #22;
      for (int s = 0; s < 2; s++) begin
         chk("rst_rsp_valid", 32'(rspv[s]), 0);
         chk("rst_rsp_data", 32'(rspd[s]), 0);
         chk("rst_grant_id", 32'(gid_o[s]), 0);
         chk("rst_busy", 32'(busy_o[s]), 0);
         chk("rst_ready", 32'(rdy[s]), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      // fixed priority: ch0 starves the others
      drv(0, 3'b111, 3'b000, 3'b000, 15'h010, 15'h020, 15'h030, 8'h00);
      repeat (3) cyc_chk(0, "fix", 3'b001);
      drv(0, 3'b000, 3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 8'h00);
      #2;
      chk("fix_idle_ad_hold", 32'(ad_o[0]), 32'h010);
      chk("fix_idle_ready", 32'(rdy[0]), 0);
      chk("fix_grant_id", 32'(gid_o[0]), 0);
      @(posedge clk); #1;
      idle(0, 2);

      // round robin: 0,1,2,0,1,2 then one more grant proves ptr wrapped to 0
      drv(1, 3'b111, 3'b000, 3'b000, 15'h010, 15'h020, 15'h030, 8'h00);
      for (int k = 0; k < 6; k++) cyc_chk(1, "rr", 3'(1 << (k % 3)));
      drv(1, 3'b000, 3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 8'h00);
      #2; chk("rr_last_grant", 32'(gid_o[1]), 2);
      @(posedge clk); #1;
      drv(1, 3'b111, 3'b000, 3'b000, 15'h010, 15'h020, 15'h030, 8'h00);
      cyc_chk(1, "rr_ptr0", 3'b001);
      idle(1, 3);

      // read latency 2 with busy window
      drv(1, 3'b010, 3'b000, 3'b000, 15'h0, 15'h1234, 15'h0, 8'h00);
      cyc_chk(1, "lat", 3'b010);
      drv(1, 3'b000, 3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 8'h00);
      chk("lat_busy_c0", 32'(busy_o[1]), 1);
      @(posedge clk); #1;
      chk("lat_busy_c1", 32'(busy_o[1]), 1);
      @(posedge clk); #1;
      chk("lat_busy_c2", 32'(busy_o[1]), 0);
      idle(1, 2);

      // burst lock: ch2 locked, ch0 competing, then ch2 alone
      drv(1, 3'b100, 3'b000, 3'b100, 15'h010, 15'h020, 15'h030, 8'h00);
      cyc_chk(1, "lock_first", 3'b100);
      drv(1, 3'b101, 3'b000, 3'b100, 15'h010, 15'h020, 15'h030, 8'h00);
      for (int k = 0; k < 9; k++) cyc_chk(1, "lock_mix", burst_exp[k]);
      drv(1, 3'b100, 3'b000, 3'b100, 15'h010, 15'h020, 15'h030, 8'h00);
      repeat (6) cyc_chk(1, "lock_alone", 3'b100);
      idle(1, 3);

      // write then read of the same address from another channel
      drv(1, 3'b001, 3'b001, 3'b000, 15'h0100, 15'h0, 15'h0, 8'h5A);
      cyc_chk(1, "wr", 3'b001);
      drv(1, 3'b010, 3'b000, 3'b000, 15'h0, 15'h0100, 15'h0, 8'h00);
      cyc_chk(1, "rd_after_wr", 3'b010);
      idle(1, 4);

      // reset one cycle after a read is accepted drops the response
      drv(1, 3'b010, 3'b000, 3'b000, 15'h0, 15'h1234, 15'h0, 8'h00);
      cyc_chk(1, "rst_rd", 3'b010);
      chk("rst_rd_busy", 32'(busy_o[1]), 1);
      drv(1, 3'b000, 3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 8'h00);
      rst_n = 1'b0;
      void'(q1.pop_back());
      #1;
      chk("mid_rst_rsp_valid", 32'(rspv[1]), 0);
      chk("mid_rst_rsp_data", 32'(rspd[1]), 0);
      chk("mid_rst_grant_id", 32'(gid_o[1]), 0);
      chk("mid_rst_busy", 32'(busy_o[1]), 0);
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
         chk("post_rst_busy", 32'(busy_o[1]), 0);
      end

      chk("f_queue_empty", q0.size(), 0);
      chk("r_queue_empty", q1.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bsram_port_arbiter.md
Name: bsram_port_arbiter

Overview:
- Parametrised N-channel arbiter that shares one single-port BSRAM port among several requesters, for example the CPU, a display prefetcher and a DMA/boot loader, all in the MEMORY_CLK domain.
- It replaces ad-hoc per-client wiring into the ram block.
- Adds fixed-priority or round-robin arbitration, bounded burst locking, and read-response routing with a configurable BSRAM read latency.

Parameters:
- NCH, 3, number of requester channels (2..8).
- AW, 15, address width.
- DW, 8, data width.
- RD_LAT, 1, BSRAM read latency in cycles from ce to valid mem_dout (1..3).
- RR_MODE, 1, 1 = round-robin, 0 = fixed priority (channel 0 highest).
- MAX_BURST, 4, maximum consecutive grants to one locked channel before forced rotation (1..15).

Ports:
- MEMORY_CLK  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  NCH  per-channel request valid.
- req_we  in  NCH  per-channel write enable (1 = write, 0 = read).
- req_lock  in  NCH  per-channel burst-lock request.
- req_addr  in  NCH*AW  per-channel address, channel i at bits [i*AW +: AW].
- req_wdata  in  NCH*DW  per-channel write data, channel i at bits [i*DW +: DW].
- req_ready  out  NCH  one-hot accept strobe.
- rsp_valid  out  NCH  one-hot read-data-valid strobe.
- rsp_data  out  DW  read data, shared by all channels.
- mem_ce  out  1  BSRAM clock enable.
- mem_we  out  1  BSRAM write enable.
- mem_ad  out  AW  BSRAM address.
- mem_din  out  DW  BSRAM write data.
- mem_dout  in  DW  BSRAM read data.
- grant_id  out  3  channel of the current grant, or of the last grant when idle.
- busy  out  1  high while any read is outstanding in the response pipeline.

Behaviour:
- Transfer rule: a transfer on channel i occurs on the rising edge where req_valid[i] and req_ready[i] are both high.
- Requester protocol: a requester holds valid, we, addr and wdata stable until accepted. req_valid may not depend on req_ready.
- req_ready and the mem_* outputs are combinational from the current req_* and the arbiter state. At most one req_ready bit is high; none is high when no channel is valid.
  - mem_ce = |req_valid.
  - mem_we, mem_ad and mem_din are muxed from the winning channel.
  - mem_ad and mem_din hold their previous values when idle.
- Fixed mode: the lowest-index valid channel wins.
- Round-robin mode: a registered pointer ptr (reset 0) marks the highest-priority channel; search order is ptr, ptr+1, ... modulo NCH. After a transfer on channel g, ptr becomes (g+1) mod NCH. ptr does not change on idle cycles.
- Burst lock:
  - If the channel granted on the previous cycle is still valid with req_lock high, and burst_cnt < MAX_BURST, it wins again regardless of mode.
  - burst_cnt (4 bits, reset 0) increments on each consecutive transfer to the same locked channel and returns to 1 on a transfer to any other channel.
  - When burst_cnt reaches MAX_BURST, that channel is excluded for one arbitration cycle if another channel is valid. If no other channel is valid, it is granted again and burst_cnt restarts at 1.
- Read pipeline:
  - A shift register of depth RD_LAT carries {valid, id} per accepted read.
  - Exactly RD_LAT cycles after a read transfer on channel i, rsp_valid[i] = 1 for one cycle and rsp_data = mem_dout.
  - Writes enter no pipeline entry and produce no response.
  - Back-to-back reads give back-to-back responses in acceptance order. Full throughput is 1 transfer per cycle.
- busy = OR of the pipeline valid bits.
- grant_id: registered, updated on each transfer, reset 0.
- Reset values: rsp_valid = 0, rsp_data = 0, ptr = 0, burst_cnt = 0, grant_id = 0, busy = 0, and all pipeline entries invalid.
- Asynchronous reset mid-operation drops in-flight responses; no rsp_valid is asserted for them after reset release.
- Simultaneous read and write requests from different channels are arbitrated identically; the loser waits.
- A channel with only req_lock high and req_valid low never blocks others.

Test Plan:
- Fixed mode, NCH=3: ch0, ch1 and ch2 all valid reads at addrs 0x010, 0x020, 0x030 for 3 cycles. Required: req_ready = 001, 001, 001 (ch0 starves others), mem_ad = 0x010 each cycle, rsp_valid[0] one cycle after each accept.
- Round-robin: all three channels valid continuously. Required: grants cycle 0, 1, 2, 0, 1, 2, ptr ends at 0 after 6 transfers, and each rsp_valid one-hot matches the channel order delayed by RD_LAT.
- Read latency, RD_LAT=2: BSRAM model preloaded 0x1234 -> 0xA5 (AW=15); ch1 reads 0x1234. Required: rsp_valid = 010 exactly 2 cycles after accept, rsp_data = 0xA5, busy high for 2 cycles.
- Burst lock, MAX_BURST=4: ch2 holds req_lock with valid; ch0 also valid.
  - Required: ch2 granted 4 consecutive cycles, then ch0 granted once, then ch2 resumes.
  - With ch0 idle instead, ch2 is granted continuously.
- Write/read mix: ch0 writes 0x5A to 0x0100, then ch1 reads 0x0100 the next cycle. Required: mem_we = 1 then 0, no rsp on ch0, and rsp_data = 0x5A on ch1.
- Reset mid-read: rst_n pulled low the cycle after a ch1 read is accepted with RD_LAT=2. Required: all outputs return to reset values immediately, and no rsp_valid appears after release.
